// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: RAW stall detection, branch flush priority,
// memory wait-state sequencing with timeout, and saturating event counters.
//
// state  | meaning
// S_IDLE | no memory access outstanding; a missed mem_ready freezes and enters S_WAIT
// S_WAIT | access outstanding, pipeline frozen, timer counting wait cycles
// S_ERR  | memory timed out; pipeline frozen until rst
module hazard_flush_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int FWD_EN      = 1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_src_valid,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic                  mem_wb_en,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  freeze_pc,
  output logic                  freeze_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  freeze_all,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      wait_cnt
);

  localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               match_ex, match_mem, hazard;
  logic               wait_frz, stall_go, flush_go;

  always_comb begin
    match_ex  = ex_wb_en  & ((id_src1 == ex_dst)  | (id_two_src & (id_src2 == ex_dst)));
    match_mem = mem_wb_en & ((id_src1 == mem_dst) | (id_two_src & (id_src2 == mem_dst)));
    if (FWD_EN != 0) hazard = id_src_valid & match_ex & ex_mem_read;
    else             hazard = id_src_valid & (match_ex | match_mem);
  end

  // Freeze beats branch beats hazard; a frozen cycle re-presents the same
  // branch/hazard once the freeze drops, so nothing is lost by masking here.
  always_comb begin
    wait_frz     = (state == S_WAIT) | ((state == S_IDLE) & mem_req & ~mem_ready);
    freeze_all   = ~rst & (wait_frz | (state == S_ERR));
    flush_go     = ~rst & ~freeze_all & branch_taken;
    stall_go     = ~rst & ~freeze_all & ~branch_taken & hazard;
    freeze_pc    = stall_go;
    freeze_if_id = stall_go;
    flush_if_id  = flush_go;
    flush_id_ex  = flush_go | stall_go;
    mem_error    = ~rst & (state == S_ERR);
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      S_IDLE: begin
        if (mem_req & ~mem_ready) begin
          state_nxt = S_WAIT;
          timer_nxt = TMR_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == TMR_W'(MEM_TIMEOUT)) begin
          state_nxt = S_ERR;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_go && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_go && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_frz && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
    end
  end

endmodule
